// File: rtl/bus_xfer_seq.sv
// bus_xfer_seq: queues "move source to destination" requests and sequences
// each one as a DRIVE cycle, which presents the source select to the
// registered bus mux, followed by a LOAD cycle, which pulses the one-hot
// destination load enable.
module bus_xfer_seq #(
    parameter int DEPTH = 4,
    parameter int SEL_W = 5,
    parameter int NDEST = 24
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SEL_W-1:0] req_src,
    input  logic [SEL_W-1:0] req_dst,
    output logic [SEL_W-1:0] sel_out,
    output logic [NDEST-1:0] load_en,
    output logic             xfer_done,
    output logic             dst_err,
    output logic             busy
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [AW:0]      FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [SEL_W-1:0] ZERO_SRC = SEL_W'(24);
    localparam logic [NDEST-1:0] ONE_HOT0 = NDEST'(1);

    typedef enum logic [1:0] {IDLE, DRIVE, LOAD} state_t;

    // Request FIFO storage and bookkeeping
    logic [2*SEL_W-1:0] mem [DEPTH];
    logic [AW-1:0]      wr_ptr, rd_ptr;
    logic [AW:0]        count;
    logic               push, pop;
    logic [SEL_W-1:0]   head_src, head_dst;

    // Sequencer state and the transfer currently in flight
    state_t             state, state_nxt;
    logic [SEL_W-1:0]   cur_src, cur_dst, cur_src_nxt, cur_dst_nxt;
    logic [SEL_W-1:0]   sel_nxt;
    logic [NDEST-1:0]   load_nxt;
    logic               done_nxt, err_nxt;

    assign req_ready = (count != FULL_CNT);
    assign push      = req_valid && req_ready;
    assign head_src  = mem[rd_ptr][2*SEL_W-1:SEL_W];
    assign head_dst  = mem[rd_ptr][SEL_W-1:0];
    assign busy      = (state != IDLE) || (count != '0);

    // FIFO payload write; the storage array carries no reset
    // NOTE: memories are not reset -- the pointers and count define which
    // entries are valid, so clearing the array would only cost logic.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {req_src, req_dst};
    end

    // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + (AW+1)'(1);
            else if (pop && !push) count <= count - (AW+1)'(1);
        end
    end

    // Next-state, pop decision and next values of the registered outputs
    // NOTE: every output of this block is assigned a default first so that no
    // path through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_nxt   = state;
        cur_src_nxt = cur_src;
        cur_dst_nxt = cur_dst;
        sel_nxt     = sel_out;
        load_nxt    = '0;
        done_nxt    = 1'b0;
        err_nxt     = 1'b0;
        pop         = 1'b0;
        unique case (state)
            IDLE, LOAD: begin
                if (count != '0) begin
                    pop         = 1'b1;
                    cur_src_nxt = head_src;
                    cur_dst_nxt = head_dst;
                    sel_nxt     = head_src;
                    state_nxt   = DRIVE;
                end else begin
                    sel_nxt   = ZERO_SRC;
                    state_nxt = IDLE;
                end
            end
            DRIVE: begin
                // The mux captures cur_src at the end of this cycle; the
                // destination is enabled during the following LOAD cycle.
                sel_nxt   = cur_src;
                state_nxt = LOAD;
                if (int'(cur_dst) < NDEST) begin
                    load_nxt = ONE_HOT0 << cur_dst;
                    done_nxt = 1'b1;
                end else begin
                    err_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                sel_nxt   = ZERO_SRC;
            end
        endcase
    end

    // State register, in-flight transfer and registered bus-side outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cur_src   <= ZERO_SRC;
            cur_dst   <= '0;
            sel_out   <= ZERO_SRC;
            load_en   <= '0;
            xfer_done <= 1'b0;
            dst_err   <= 1'b0;
        end else begin
            state     <= state_nxt;
            cur_src   <= cur_src_nxt;
            cur_dst   <= cur_dst_nxt;
            sel_out   <= sel_nxt;
            load_en   <= load_nxt;
            xfer_done <= done_nxt;
            dst_err   <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bus_xfer_seq.sv
// Directed bench for bus_xfer_seq: single transfer, back-to-back transfers,
// FIFO-full back-pressure, illegal destination, mid-operation reset and
// push/pop on the same edge.
module tb_bus_xfer_seq;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [4:0]  req_src;
    logic [4:0]  req_dst;
    logic [4:0]  sel_out;
    logic [23:0] load_en;
    logic        xfer_done;
    logic        dst_err;
    logic        busy;

    int total = 0;
    int bad   = 0;

    bus_xfer_seq #(.DEPTH(4), .SEL_W(5), .NDEST(24)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_src   (req_src),
        .req_dst   (req_dst),
        .sel_out   (sel_out),
        .load_en   (load_en),
        .xfer_done (xfer_done),
        .dst_err   (dst_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and sample 1 time unit later; also checks the
    // invariants that hold in every cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        check("onehot0_load_en", 32'($onehot0(load_en)), 32'd1);
        check("load_en_with_done", 32'(|load_en), 32'(xfer_done));
    endtask

    int got [8];
    int n_got;
    int idx;
    logic acc;

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_src   = '0;
        req_dst   = '0;
        #12;
        check("rst_sel_out", 32'(sel_out), 32'd24);
        check("rst_load_en", 32'(load_en), 32'd0);
        check("rst_done", 32'(xfer_done), 32'd0);
        check("rst_err", 32'(dst_err), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;

        // 1. Single transfer PC -> R5
        req_valid = 1'b1; req_src = 5'd20; req_dst = 5'd5;
        tick();                                   // T: push
        req_valid = 1'b0;
        check("t1_busy_T", 32'(busy), 32'd1);
        check("t1_sel_T", 32'(sel_out), 32'd24);
        tick();                                   // T+1: DRIVE
        check("t1_sel_T1", 32'(sel_out), 32'd20);
        check("t1_load_T1", 32'(load_en), 32'd0);
        tick();                                   // T+2: LOAD
        check("t1_sel_T2", 32'(sel_out), 32'd20);
        check("t1_load_T2", 32'(load_en), 32'h000020);
        check("t1_done_T2", 32'(xfer_done), 32'd1);
        tick();                                   // T+3: IDLE
        check("t1_sel_T3", 32'(sel_out), 32'd24);
        check("t1_load_T3", 32'(load_en), 32'd0);
        check("t1_done_T3", 32'(xfer_done), 32'd0);
        check("t1_busy_T3", 32'(busy), 32'd0);

        // 2. Back-to-back: (3->7), (21->16), (24->0)
        req_valid = 1'b1; req_src = 5'd3; req_dst = 5'd7;
        tick();                                   // A
        req_src = 5'd21; req_dst = 5'd16;
        tick();                                   // A+1
        check("t2_sel_1", 32'(sel_out), 32'd3);
        check("t2_load_1", 32'(load_en), 32'd0);
        req_src = 5'd24; req_dst = 5'd0;
        tick();                                   // A+2
        req_valid = 1'b0;
        check("t2_sel_2", 32'(sel_out), 32'd3);
        check("t2_load_2", 32'(load_en), 32'h000080);
        tick();
        check("t2_sel_3", 32'(sel_out), 32'd21);
        check("t2_load_3", 32'(load_en), 32'd0);
        tick();
        check("t2_sel_4", 32'(sel_out), 32'd21);
        check("t2_load_4", 32'(load_en), 32'h010000);
        tick();
        check("t2_sel_5", 32'(sel_out), 32'd24);
        check("t2_load_5", 32'(load_en), 32'd0);
        tick();
        check("t2_sel_6", 32'(sel_out), 32'd24);
        check("t2_load_6", 32'(load_en), 32'h000001);
        check("t2_busy_6", 32'(busy), 32'd1);
        tick();
        check("t2_busy_7", 32'(busy), 32'd0);
        check("t2_sel_7", 32'(sel_out), 32'd24);

        // 3. Full FIFO: requester holds each of 8 requests (i -> i+8) until accepted
        idx   = 0;
        n_got = 0;
        for (int k = 0; k < 20; k++) begin
            req_valid = (idx < 8);
            req_src   = 5'(idx);
            req_dst   = 5'(idx + 8);
            acc       = req_valid && req_ready;
            tick();
            if (acc) idx++;
            if (xfer_done) begin
                for (int b = 0; b < 24; b++)
                    if (load_en[b] && n_got < 8) got[n_got] = b;
                n_got++;
            end
            if (k == 5) check("t3_ready_E5", 32'(req_ready), 32'd1);
            if (k == 6) check("t3_ready_E6", 32'(req_ready), 32'd0);
            if (k == 7) check("t3_ready_E7", 32'(req_ready), 32'd1);
            if (k == 8) check("t3_ready_E8", 32'(req_ready), 32'd0);
            if (k == 9) check("t3_ready_E9", 32'(req_ready), 32'd1);
        end
        req_valid = 1'b0;
        check("t3_accepted", 32'(idx), 32'd8);
        check("t3_completed", 32'(n_got), 32'd8);
        for (int i = 0; i < 8; i++) check("t3_order", 32'(got[i]), 32'(i + 8));
        check("t3_busy_end", 32'(busy), 32'd0);

        // 4. Illegal destination (1->28) followed by a legal one (2->3)
        req_valid = 1'b1; req_src = 5'd1; req_dst = 5'd28;
        tick();                                   // T
        req_src = 5'd2; req_dst = 5'd3;
        tick();                                   // T+1: DRIVE bad
        req_valid = 1'b0;
        check("t4_sel_drive", 32'(sel_out), 32'd1);
        check("t4_err_drive", 32'(dst_err), 32'd0);
        tick();                                   // T+2: LOAD bad
        check("t4_err", 32'(dst_err), 32'd1);
        check("t4_load", 32'(load_en), 32'd0);
        check("t4_done", 32'(xfer_done), 32'd0);
        tick();                                   // T+3: DRIVE good
        check("t4_err_clear", 32'(dst_err), 32'd0);
        check("t4_sel_next", 32'(sel_out), 32'd2);
        tick();                                   // T+4: LOAD good
        check("t4_load_next", 32'(load_en), 32'h000008);
        check("t4_done_next", 32'(xfer_done), 32'd1);
        tick();
        check("t4_busy_end", 32'(busy), 32'd0);

        // 5. Reset during DRIVE of (9->2) with two requests queued behind it
        req_valid = 1'b1; req_src = 5'd4; req_dst = 5'd6;
        tick();                                   // A
        req_src = 5'd9; req_dst = 5'd2;
        tick();                                   // A+1: DRIVE (4->6)
        req_src = 5'd10; req_dst = 5'd11;
        tick();                                   // A+2: LOAD (4->6)
        req_src = 5'd12; req_dst = 5'd13;
        tick();                                   // A+3: DRIVE (9->2)
        req_valid = 1'b0;
        check("t5_sel_drive", 32'(sel_out), 32'd9);
        check("t5_busy_pre", 32'(busy), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_sel_rst", 32'(sel_out), 32'd24);
        check("t5_load_rst", 32'(load_en), 32'd0);
        check("t5_busy_rst", 32'(busy), 32'd0);
        check("t5_ready_rst", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("t5_no_load", 32'(load_en), 32'd0);
            check("t5_idle", 32'(busy), 32'd0);
        end

        // 6. Push and pop on the same edge at count=1 during LOAD
        req_valid = 1'b1; req_src = 5'd6; req_dst = 5'd1;
        tick();                                   // A: push
        req_valid = 1'b0;
        tick();                                   // A+1: DRIVE (6->1)
        check("t6_sel_1", 32'(sel_out), 32'd6);
        req_valid = 1'b1; req_src = 5'd7; req_dst = 5'd2;
        tick();                                   // A+2: LOAD (6->1), count=1
        check("t6_load_2", 32'(load_en), 32'h000002);
        req_src = 5'd8; req_dst = 5'd3;
        check("t6_ready_2", 32'(req_ready), 32'd1);
        tick();                                   // A+3: push + pop
        req_valid = 1'b0;
        check("t6_sel_3", 32'(sel_out), 32'd7);
        check("t6_ready_3", 32'(req_ready), 32'd1);
        tick();                                   // A+4: LOAD (7->2)
        check("t6_load_4", 32'(load_en), 32'h000004);
        tick();                                   // A+5: DRIVE (8->3)
        check("t6_sel_5", 32'(sel_out), 32'd8);
        check("t6_busy_5", 32'(busy), 32'd1);
        tick();                                   // A+6: LOAD (8->3)
        check("t6_load_6", 32'(load_en), 32'h000008);
        tick();                                   // A+7: IDLE
        check("t6_busy_7", 32'(busy), 32'd0);
        check("t6_sel_7", 32'(sel_out), 32'd24);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
